// File: rtl/decode_queue.sv
// Instruction decode queue: circular buffer of fetched instructions.
// Each entry carries a predecode (class, 32-bit-op flag, illegal flag) computed at push time.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [3:0]                 out_class,
  output logic                       out_word,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [3:0]      cls;
    logic            word;
    logic            illegal;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [3:0]         w_cls;
  entry_t             w_entry;
  entry_t             w_head;

  // Full queue stays not-ready even when the head is popped this cycle.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != CNT_W'(0));
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // Predecode of the incoming word from its major opcode.
  always_comb begin
    w_cls = 4'd15;
    case (in_instr[6:2])
      5'b00000: w_cls = 4'd2;
      5'b00100: w_cls = 4'd1;
      5'b00101: w_cls = 4'd8;
      5'b00110: w_cls = 4'd11;
      5'b01000: w_cls = 4'd3;
      5'b01100: w_cls = 4'd0;
      5'b01101: w_cls = 4'd7;
      5'b01110: w_cls = 4'd10;
      5'b11000: w_cls = 4'd4;
      5'b11001: w_cls = 4'd6;
      5'b11011: w_cls = 4'd5;
      5'b11100: w_cls = 4'd9;
      default:  w_cls = 4'd15;
    endcase
    if (in_instr[1:0] != 2'b11) w_cls = 4'd15;
    w_entry.pc      = in_pc;
    w_entry.instr   = in_instr;
    w_entry.cls     = w_cls;
    w_entry.word    = (w_cls == 4'd10) || (w_cls == 4'd11);
    w_entry.illegal = (w_cls == 4'd15);
  end

  // Storage array; cleared on reset so head outputs are never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign out_instr   = w_head.instr;
  assign out_pc      = w_head.pc;
  assign out_rd      = w_head.instr[11:7];
  assign out_rs1     = w_head.instr[19:15];
  assign out_rs2     = w_head.instr[24:20];
  assign out_class   = w_head.cls;
  assign out_word    = w_head.word;
  assign out_illegal = w_head.illegal;
  assign occupancy   = r_count;

endmodule
